// File: rtl/reset_sequencer_pkg.sv
// Shared types for the Retro16 reset sequencer: reset causes, FSM states and
// the helper that sizes counters.
package retro16_reset_pkg;

    typedef enum logic [1:0] {
        CAUSE_POWER    = 2'd0,
        CAUSE_BUTTON   = 2'd1,
        CAUSE_SOFTWARE = 2'd2
    } reset_cause_e;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } rst_seq_state_e;

    // Bits needed to hold 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle of the reset sequencer. The slave side is the
// sequencer, and the master side drives the button and software request.
interface reset_sequencer_if #(
    parameter int unsigned NUM_DOMAINS = 3
);
    import retro16_reset_pkg::*;

    logic                   btn;
    logic                   sw_rst_req;
    logic [NUM_DOMAINS-1:0] rst_out;
    logic                   ready;
    logic                   busy;
    reset_cause_e           last_cause;

    modport master (
        output btn, sw_rst_req,
        input  rst_out, ready, busy, last_cause
    );

    modport slave (
        input  btn, sw_rst_req,
        output rst_out, ready, busy, last_cause
    );

endinterface

// File: rtl/reset_sequencer_sync_debounce.sv
// Button conditioning: a 2-flop synchroniser, then polarity normalisation
// (1 = pressed) and a consecutive-sample debouncer with a press pulse.
module sync_debounce
    import retro16_reset_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic        IDLE_RAW = ACTIVE_LOW;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          press_q;
    logic          sample;

    assign sample = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

    // Count samples that disagree with the accepted level; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {2{IDLE_RAW}};
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            press_q <= 1'b0;
            if (sample == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q   <= '0;
                level_q <= sample;
                press_q <= sample;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/reset_sequencer.sv
// Retro16 reset controller: asserts all domain resets together, then releases
// them one by one (bit 0 first), and records what caused the last reset.
module reset_sequencer
    import retro16_reset_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES     = 8,
    parameter int unsigned NUM_DOMAINS     = 3,
    parameter int unsigned STAGE_GAP       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    reset_sequencer_if.slave bus
);

    localparam int unsigned HW = cnt_width(HOLD_CYCLES);
    localparam int unsigned GW = cnt_width(STAGE_GAP);

    rst_seq_state_e         state_q;
    logic [HW-1:0]          hold_q;
    logic [GW-1:0]          gap_q;
    logic [NUM_DOMAINS-1:0] rst_out_q;
    logic [NUM_DOMAINS-1:0] rst_out_shift;
    logic                   ready_q;
    logic                   busy_q;
    reset_cause_e           cause_q;
    logic                   btn_level;
    logic                   btn_press;

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (BTN_ACTIVE_LOW)
    ) u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (bus.btn),
        .level_o (btn_level),
        .press_o (btn_press)
    );

    // Releasing a domain shifts a zero in from the bottom: 111 -> 110 -> 100 -> 000.
    assign rst_out_shift = rst_out_q << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ASSERT;
            hold_q    <= '0;
            gap_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            cause_q   <= CAUSE_POWER;
        end else if (btn_press || bus.sw_rst_req) begin
            state_q   <= ASSERT;
            hold_q    <= '0;
            gap_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            cause_q   <= btn_press ? CAUSE_BUTTON : CAUSE_SOFTWARE;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (btn_level) begin
                        hold_q <= '0;
                    end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                        hold_q    <= '0;
                        rst_out_q <= rst_out_shift;
                        if (rst_out_shift == '0) begin
                            state_q <= RUN;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= RELEASE;
                        end
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                RELEASE: begin
                    if (gap_q == GW'(STAGE_GAP - 1)) begin
                        gap_q     <= '0;
                        rst_out_q <= rst_out_shift;
                        if (rst_out_shift == '0) begin
                            state_q <= RUN;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rst_out    = rst_out_q;
    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.last_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues each expected output
// change with its cycle number, and monitors pop and compare on every change.
module tb_reset_sequencer;

    typedef struct {
        int         cyc;
        logic [2:0] ro;
        logic       rdy;
        logic       bsy;
        logic [1:0] cause;
        string      tag;
    } exp_t;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic rst1 = 1'b0;
    int   cyc  = 0;
    int   n_vec = 0;
    int   n_mis = 0;

    exp_t q0[$];
    exp_t q1[$];

    reset_sequencer_if #(.NUM_DOMAINS(3)) bus0 ();
    reset_sequencer_if #(.NUM_DOMAINS(1)) bus1 ();

    reset_sequencer #(
        .HOLD_CYCLES(8), .NUM_DOMAINS(3), .STAGE_GAP(4),
        .DEBOUNCE_CYCLES(16), .BTN_ACTIVE_LOW(1'b1)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    reset_sequencer #(
        .HOLD_CYCLES(1), .NUM_DOMAINS(1), .STAGE_GAP(4),
        .DEBOUNCE_CYCLES(16), .BTN_ACTIVE_LOW(1'b1)
    ) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push0(input int c, input logic [2:0] ro, input logic rdy,
                         input logic bsy, input logic [1:0] cause, input string tag);
        exp_t e;
        e.cyc = c; e.ro = ro; e.rdy = rdy; e.bsy = bsy; e.cause = cause; e.tag = tag;
        q0.push_back(e);
    endtask

    task automatic push1(input int c, input logic [2:0] ro, input logic rdy,
                         input logic bsy, input logic [1:0] cause, input string tag);
        exp_t e;
        e.cyc = c; e.ro = ro; e.rdy = rdy; e.bsy = bsy; e.cause = cause; e.tag = tag;
        q1.push_back(e);
    endtask

    // Release staircase following a reset source that clears at edge 'base'.
    task automatic seq0(input int base, input logic [1:0] cause, input string tag);
        push0(base + 8,  3'b110, 1'b0, 1'b1, cause, {tag, " rel0"});
        push0(base + 12, 3'b100, 1'b0, 1'b1, cause, {tag, " rel1"});
        push0(base + 16, 3'b000, 1'b1, 1'b0, cause, {tag, " rel2"});
    endtask

    task automatic cmp(input exp_t e, input int c, input logic [2:0] ro,
                       input logic rdy, input logic bsy, input logic [1:0] cause);
        n_vec++;
        if (c != e.cyc || ro !== e.ro || rdy !== e.rdy || bsy !== e.bsy || cause !== e.cause) begin
            n_mis++;
            $display("FAIL %s: got cycle=%0d rst_out=%b ready=%b busy=%b cause=%0d, expected cycle=%0d rst_out=%b ready=%b busy=%b cause=%0d",
                     e.tag, c, ro, rdy, bsy, cause, e.cyc, e.ro, e.rdy, e.bsy, e.cause);
        end
    endtask

    logic [6:0] prev0, cur0, prev1, cur1;
    bit         first0, first1;

    initial begin : mon0
        exp_t e;
        first0 = 1'b1;
        prev0  = '0;
        forever begin
            @(negedge clk or posedge rst);
            #1;
            cur0 = {bus0.rst_out, bus0.ready, bus0.busy, bus0.last_cause};
            if (first0 || cur0 !== prev0) begin
                first0 = 1'b0;
                prev0  = cur0;
                if (q0.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL dut0 unexpected change: cycle=%0d rst_out=%b ready=%b busy=%b cause=%0d",
                             cyc, bus0.rst_out, bus0.ready, bus0.busy, bus0.last_cause);
                end else begin
                    e = q0.pop_front();
                    cmp(e, cyc, bus0.rst_out, bus0.ready, bus0.busy, bus0.last_cause);
                end
            end
        end
    end

    initial begin : mon1
        exp_t e;
        first1 = 1'b1;
        prev1  = '0;
        forever begin
            @(negedge clk or posedge rst1);
            #1;
            cur1 = {2'b00, bus1.rst_out, bus1.ready, bus1.busy, bus1.last_cause};
            if (first1 || cur1 !== prev1) begin
                first1 = 1'b0;
                prev1  = cur1;
                if (q1.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL dut1 unexpected change: cycle=%0d rst_out=%b ready=%b busy=%b cause=%0d",
                             cyc, bus1.rst_out, bus1.ready, bus1.busy, bus1.last_cause);
                end else begin
                    e = q1.pop_front();
                    cmp(e, cyc, {2'b00, bus1.rst_out}, bus1.ready, bus1.busy, bus1.last_cause);
                end
            end
        end
    end

    initial begin : stim
        int c;
        bus0.btn = 1'b1;
        bus0.sw_rst_req = 1'b0;
        bus1.btn = 1'b1;
        bus1.sw_rst_req = 1'b0;

        // Power-on reset values, then the default release staircase.
        push0(0, 3'b111, 1'b0, 1'b1, 2'd0, "t1 reset");
        push1(0, 3'b001, 1'b0, 1'b1, 2'd0, "n1 reset");
        #1;
        rst  = 1'b1;
        rst1 = 1'b1;
        repeat (3) @(negedge clk);
        c = cyc;
        seq0(c, 2'd0, "t1");
        push1(c + 1, 3'b000, 1'b1, 1'b0, 2'd0, "n1 ready");
        rst  = 1'b0;
        rst1 = 1'b0;
        repeat (20) @(negedge clk);

        // Short glitch: shorter than the debounce window, so nothing may change.
        bus0.btn = 1'b0;
        repeat (5) @(negedge clk);
        bus0.btn = 1'b1;
        repeat (30) @(negedge clk);

        // Held press: reset 19 edges after it is sampled, release after debounced let-go.
        c = cyc;
        push0(c + 19, 3'b111, 1'b0, 1'b1, 2'd1, "t3 press");
        bus0.btn = 1'b0;
        repeat (40) @(negedge clk);
        bus0.btn = 1'b1;
        seq0(c + 58, 2'd1, "t3");
        repeat (40) @(negedge clk);

        // Software request from RUN, then again while rst_out=100.
        c = cyc;
        push0(c + 1,  3'b111, 1'b0, 1'b1, 2'd2, "t4 sw run");
        push0(c + 9,  3'b110, 1'b0, 1'b1, 2'd2, "t4 rel0");
        push0(c + 13, 3'b100, 1'b0, 1'b1, 2'd2, "t4 rel1");
        bus0.sw_rst_req = 1'b1;
        @(negedge clk);
        bus0.sw_rst_req = 1'b0;
        repeat (13) @(negedge clk);
        push0(c + 15, 3'b111, 1'b0, 1'b1, 2'd2, "t4 sw mid");
        bus0.sw_rst_req = 1'b1;
        @(negedge clk);
        bus0.sw_rst_req = 1'b0;
        seq0(c + 15, 2'd2, "t4");
        repeat (25) @(negedge clk);

        // Software request on the same edge as the debounced press: button wins.
        c = cyc;
        push0(c + 19, 3'b111, 1'b0, 1'b1, 2'd1, "t5 tie");
        bus0.btn = 1'b0;
        repeat (18) @(negedge clk);
        bus0.sw_rst_req = 1'b1;
        @(negedge clk);
        bus0.sw_rst_req = 1'b0;
        @(negedge clk);
        bus0.btn = 1'b1;
        seq0(c + 38, 2'd1, "t5");
        repeat (40) @(negedge clk);

        // Asynchronous hard reset between edges must act with no clock edge.
        @(posedge clk);
        #2;
        push0(cyc, 3'b111, 1'b0, 1'b1, 2'd0, "t6 async");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        c = cyc;
        seq0(c, 2'd0, "t6");
        rst = 1'b0;
        repeat (25) @(negedge clk);

        n_vec++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_mis++;
            $display("FAIL drain: pending expectations dut0=%0d dut1=%0d, required 0 and 0",
                     q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised reset controller for the Retro16 top level. It replaces the fixed 3-bit power-on counter and the "power-on OR button" gating. It generates NUM_DOMAINS active-high reset outputs (e.g. video, CPU, peripherals) that all assert together and then release one at a time in a staggered sequence. It also debounces the external button, accepts a software reset request and records the cause of the last reset.

Parameters:
HOLD_CYCLES, 8, clock edges all domains stay in reset after the reset source clears (>=1)
NUM_DOMAINS, 3, number of reset output domains (>=1)
STAGE_GAP, 4, clock edges between successive domain releases (>=1)
DEBOUNCE_CYCLES, 16, consecutive identical synchronised button samples required to accept a new level (>=1)
BTN_ACTIVE_LOW, 1, 1 means btn is pressed when 0; 0 means pressed when 1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high hard/power-on reset
btn  input  1  raw external reset button, asynchronous to clk
sw_rst_req  input  1  synchronous single-cycle software reset request
rst_out  output  NUM_DOMAINS  active-high domain resets; bit 0 releases first
ready  output  1  high when all domains are released
busy  output  1  high in ASSERT or RELEASE
last_cause  output  2  cause of most recent reset: 0 POWER, 1 BUTTON, 2 SOFTWARE

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-high, named rst. While rst=1:
  - rst_out all ones, ready=0, busy=1, last_cause=POWER (0)
  - state=ASSERT, all counters 0
  - debounced button level = not pressed
- Outputs: all registered. rst_out asserts asynchronously only via rst; every other assertion is synchronous (next edge).
- Button path:
  - 2-flop synchroniser, then polarity normalise.
  - Debounce counter counts consecutive samples that differ from the current debounced level and clears on any sample equal to it.
  - The debounced level flips when DEBOUNCE_CYCLES is reached.
  - A press event is a debounced not-pressed -> pressed transition.
- FSM states: ASSERT, RELEASE, RUN.
  - ASSERT:
    - rst_out all ones.
    - hold_cnt increments each edge while the debounced button is not pressed; it is held at 0 while pressed.
    - When hold_cnt reaches HOLD_CYCLES-1 -> RELEASE, and rst_out[0] clears on that same edge.
  - RELEASE:
    - gap_cnt counts 0..STAGE_GAP-1.
    - On wrap, clear the next rst_out bit, lowest index first.
    - On the edge that clears rst_out[NUM_DOMAINS-1] -> RUN, with ready=1 and busy=0 on that edge.
    - If NUM_DOMAINS=1, ASSERT goes directly to RUN.
  - RUN: hold outputs.
- Reset triggers:
  - A press event or sw_rst_req=1 in any state, including mid-RELEASE, restarts the sequence: next edge -> ASSERT, rst_out all ones, ready=0, counters cleared, last_cause updated.
  - If both occur on the same edge, BUTTON wins.
  - sw_rst_req while already in ASSERT restarts hold_cnt and sets last_cause=SOFTWARE.
- Timing (from the first edge after rst falls, button idle): rst_out[i] falls at edge HOLD_CYCLES + i*STAGE_GAP; ready rises at edge HOLD_CYCLES + (NUM_DOMAINS-1)*STAGE_GAP.
- Counter widths: $clog2(max(param)+1); counters never wrap past their terminal count.
- last_cause changes only on a reset trigger or rst.

Decomposition:
- Package retro16_reset_pkg:
  - reset_cause_e enum (CAUSE_POWER=0, CAUSE_BUTTON=1, CAUSE_SOFTWARE=2)
  - rst_seq_state_e enum (ASSERT, RELEASE, RUN)
- Sub-module sync_debounce (params DEBOUNCE_CYCLES, ACTIVE_LOW): synchroniser plus debounce, outputs a level and a press pulse.
- Top-level integration: Retro16 drives vga_display reset from rst_out[0].

Test Plan:
1. Defaults; release rst, button idle, no requests -> rst_out 3'b111 until edge 8, 3'b110 at edge 8, 3'b100 at edge 12, 3'b000 and ready=1 at edge 16; last_cause=0.
2. In RUN, 5-cycle button glitch (pressed for 5 cycles < 16) -> no change; ready stays 1.
3. In RUN, button pressed and held 40 cycles -> rst_out=3'b111 about 19 edges after the press edge (2 sync + 16 debounce + 1 FSM), last_cause=1. After the debounced release, the same 8/12/16 release sequence follows.
4. Single-cycle sw_rst_req while rst_out=3'b100 (mid-RELEASE) -> next edge rst_out=3'b111, ready=0, last_cause=2; full sequence replays.
5. sw_rst_req on the same edge as the debounced press event -> last_cause=1.
6. Assert rst asynchronously mid-RUN between edges -> rst_out=3'b111 immediately with no clock edge; last_cause=0. Also repeat test 1 with NUM_DOMAINS=1, HOLD_CYCLES=1 -> ready at edge 1.
